// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches the execute-stage results for the memory
// stage, forms the branch target and branch decision, and keeps saturating
// counts of retired instructions and taken branches.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [1:0]        wb_ctrl,
  input  logic [2:0]        m_ctrl,
  output logic              valid_out,
  output logic [DATA_W-1:0] target_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic [1:0]        wb_ctrl_out,
  output logic              memread_out,
  output logic              memwrite_out,
  output logic              pcsrc,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic en);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (en && (cnt != CNT_MAX)) res = cnt + CNT_ONE;
    return res;
  endfunction

  logic signed [DATA_W-1:0] imm_s_p0;
  logic signed [DATA_W-1:0] offset_p0;
  logic [DATA_W-1:0]        target_p0;
  logic                     take_p0;
  logic                     capture_p0;

  logic                     vld_p1;
  logic                     pcsrc_p1;
  logic                     memread_p1;
  logic                     memwrite_p1;
  logic [1:0]               wb_ctrl_p1;
  logic [DATA_W-1:0]        target_p1;
  logic                     zero_p1;
  logic [DATA_W-1:0]        alu_result_p1;
  logic [DATA_W-1:0]        rt_data_p1;
  logic [REG_W-1:0]         write_reg_p1;
  logic [CNT_W-1:0]         retired_p1;
  logic [CNT_W-1:0]         taken_p1;

  // ---- stage p0: execute-side combinational terms ----
  // Word-scaled signed offset added to PC+4; the sum wraps modulo 2^DATA_W.
  always_comb begin
    imm_s_p0   = signed'(imm_ext);
    offset_p0  = imm_s_p0 <<< 2;
    target_p0  = npc + $unsigned(offset_p0);
    take_p0    = m_ctrl[2] & alu_zero;
    capture_p0 = in_valid & ~stall & ~flush;
  end

  // ---- stage p1: EX/MEM register ----
  // Control bits: flush and bubbles clear them so nothing downstream commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      pcsrc_p1    <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      wb_ctrl_p1  <= 2'b00;
    end else if (flush || (!stall && !in_valid)) begin
      vld_p1      <= 1'b0;
      pcsrc_p1    <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      wb_ctrl_p1  <= 2'b00;
    end else if (!stall) begin
      vld_p1      <= 1'b1;
      pcsrc_p1    <= take_p0;
      memread_p1  <= m_ctrl[1];
      memwrite_p1 <= m_ctrl[0];
      wb_ctrl_p1  <= wb_ctrl;
    end
  end

  // Data payload: loaded only on a real capture, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_p1     <= '0;
      zero_p1       <= 1'b0;
      alu_result_p1 <= '0;
      rt_data_p1    <= '0;
      write_reg_p1  <= '0;
    end else if (capture_p0) begin
      target_p1     <= target_p0;
      zero_p1       <= alu_zero;
      alu_result_p1 <= alu_result;
      rt_data_p1    <= rt_data;
      write_reg_p1  <= write_reg;
    end
  end

  // Event counters advance only when an instruction is actually captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_p1 <= '0;
      taken_p1   <= '0;
    end else if (capture_p0) begin
      retired_p1 <= sat_inc(retired_p1, 1'b1);
      taken_p1   <= sat_inc(taken_p1, take_p0);
    end
  end

  assign valid_out      = vld_p1;
  assign pcsrc          = pcsrc_p1;
  assign memread_out    = memread_p1;
  assign memwrite_out   = memwrite_p1;
  assign wb_ctrl_out    = wb_ctrl_p1;
  assign target_out     = target_p1;
  assign zero_out       = zero_p1;
  assign alu_result_out = alu_result_p1;
  assign rt_data_out    = rt_data_p1;
  assign write_reg_out  = write_reg_p1;
  assign retired_cnt    = retired_p1;
  assign taken_cnt      = taken_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed steps followed by random traffic, every
// output compared against a behavioural reference after each clock edge.
module tb_ex_mem_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] npc;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] rt_data;
  logic [REG_W-1:0]  write_reg;
  logic [1:0]        wb_ctrl;
  logic [2:0]        m_ctrl;
  logic              valid_out;
  logic [DATA_W-1:0] target_out;
  logic              zero_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] rt_data_out;
  logic [REG_W-1:0]  write_reg_out;
  logic [1:0]        wb_ctrl_out;
  logic              memread_out;
  logic              memwrite_out;
  logic              pcsrc;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  taken_cnt;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .npc(npc), .imm_ext(imm_ext),
    .alu_result(alu_result), .alu_zero(alu_zero), .rt_data(rt_data),
    .write_reg(write_reg), .wb_ctrl(wb_ctrl), .m_ctrl(m_ctrl),
    .valid_out(valid_out), .target_out(target_out), .zero_out(zero_out),
    .alu_result_out(alu_result_out), .rt_data_out(rt_data_out),
    .write_reg_out(write_reg_out), .wb_ctrl_out(wb_ctrl_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out), .pcsrc(pcsrc),
    .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  // Reference state: what the memory stage should be seeing.
  logic        e_valid, e_zero, e_mr, e_mw, e_pcsrc;
  logic [31:0] e_target, e_alu, e_rt;
  logic [4:0]  e_wr;
  logic [1:0]  e_wb;
  int          e_ret, e_tak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_zero = 0; e_mr = 0; e_mw = 0; e_pcsrc = 0;
    e_target = 0; e_alu = 0; e_rt = 0; e_wr = 0; e_wb = 0;
    e_ret = 0; e_tak = 0;
  endtask

  // One clock edge as seen from the pipeline's point of view.
  task automatic model_edge();
    logic taken;
    if (flush || (!stall && !in_valid)) begin
      e_valid = 0; e_pcsrc = 0; e_mr = 0; e_mw = 0; e_wb = 0;
    end else if (!stall) begin
      taken    = m_ctrl[2] && alu_zero;
      e_valid  = 1;
      e_pcsrc  = taken;
      e_mr     = m_ctrl[1];
      e_mw     = m_ctrl[0];
      e_wb     = wb_ctrl;
      e_target = npc + imm_ext * 32'd4;
      e_zero   = alu_zero;
      e_alu    = alu_result;
      e_rt     = rt_data;
      e_wr     = write_reg;
      if (e_ret < CNT_MAX) e_ret++;
      if (taken && e_tak < CNT_MAX) e_tak++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    32'(valid_out),      32'(e_valid));
    chk({tag, ".target"},   target_out,          e_target);
    chk({tag, ".zero"},     32'(zero_out),       32'(e_zero));
    chk({tag, ".alu"},      alu_result_out,      e_alu);
    chk({tag, ".rt"},       rt_data_out,         e_rt);
    chk({tag, ".wr"},       32'(write_reg_out),  32'(e_wr));
    chk({tag, ".wb"},       32'(wb_ctrl_out),    32'(e_wb));
    chk({tag, ".memread"},  32'(memread_out),    32'(e_mr));
    chk({tag, ".memwrite"}, 32'(memwrite_out),   32'(e_mw));
    chk({tag, ".pcsrc"},    32'(pcsrc),          32'(e_pcsrc));
    chk({tag, ".retired"},  32'(retired_cnt),    32'(e_ret));
    chk({tag, ".taken"},    32'(taken_cnt),      32'(e_tak));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_ex(input logic v, input logic [31:0] n, input logic [31:0] imm,
                        input logic [31:0] alu, input logic z, input logic [31:0] rt,
                        input logic [4:0] wr, input logic [1:0] wb, input logic [2:0] m);
    in_valid = v; npc = n; imm_ext = imm; alu_result = alu; alu_zero = z;
    rt_data = rt; write_reg = wr; wb_ctrl = wb; m_ctrl = m;
  endtask

  task automatic rand_ex();
    set_ex(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), $urandom, 5'($urandom), 2'($urandom),
           3'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset0");
    rst_n = 1'b1;

    // Capture something non-zero, then pull reset mid-cycle.
    set_ex(1, 32'h200, 32'h3, 32'hFFFF_FFFF, 1, 32'h55, 5'd3, 2'b11, 3'b111);
    cycle("pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    #3 rst_n = 1'b1;

    // ALU subtract 10-7.
    set_ex(1, 32'h20, 32'h1, 32'd3, 0, 32'h99, 5'd8, 2'b10, 3'b000);
    cycle("sub");
    chk("sub.alu_const", alu_result_out, 32'd3);
    chk("sub.ret_const", 32'(retired_cnt), 32'd1);

    // Taken and not-taken branch.
    set_ex(1, 32'h100, 32'd4, 32'd0, 1, 32'h0, 5'd0, 2'b00, 3'b100);
    cycle("beq_taken");
    chk("beq.target_const", target_out, 32'h110);
    chk("beq.pcsrc_const", 32'(pcsrc), 32'd1);
    alu_zero = 0;
    cycle("beq_not");

    // Load, then three stalls with wandering inputs, then stall+flush.
    set_ex(1, 32'h300, 32'h8, 32'h40, 0, 32'h7, 5'd9, 2'b11, 3'b010);
    cycle("load");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      cycle("stall");
    end
    flush = 1'b1;
    cycle("stall_flush");
    chk("flush.alu_const", alu_result_out, 32'h40);
    stall = 1'b0; flush = 1'b0;

    // Bubble carrying store control, then negative branch offset.
    set_ex(0, 32'h44, 32'h2, 32'h80, 1, 32'h12, 5'd4, 2'b11, 3'b011);
    cycle("bubble");
    set_ex(1, 32'h10, 32'hFFFF_FFF8, 32'h0, 1, 32'h0, 5'd0, 2'b00, 3'b100);
    cycle("neg_off");
    chk("neg.target_const", target_out, 32'hFFFF_FFF0);

    // Twenty back-to-back captures drive the counters to saturation.
    for (int i = 0; i < 20; i++) begin
      set_ex(1, $urandom, $urandom, $urandom, 1'(i % 2), $urandom, 5'($urandom),
             2'($urandom), 3'b100);
      cycle("sat");
    end
    chk("sat.ret_const", 32'(retired_cnt), 32'd15);
    cycle("sat_extra");
    chk("sat.ret_hold", 32'(retired_cnt), 32'd15);

    // Fresh counters, then random traffic with stalls and flushes.
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst2");
    #3 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_ex();
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute stage (ALU, branch-target adder) and the memory stage.
- Captures the ALU result and zero flag, store data, destination register and WB/M control bits each clock.
- Computes the branch-target address, the target plus branch decision (pcsrc), and two saturating event counters.
- Supports stall (hold), flush (insert bubble) and a valid bit so bubbles never write memory or registers.

Parameters:
- DATA_W, 32, datapath width of ALU result, store data and PC.
- REG_W, 5, destination register index width.
- CNT_W, 16, width of the retired-instruction and taken-branch counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all registered state this cycle.
- flush  in  1  load a bubble this cycle.
- in_valid  in  1  execute-stage instruction is valid.
- npc  in  DATA_W  PC+4 of the execute-stage instruction.
- imm_ext  in  DATA_W  sign-extended immediate.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.
- rt_data  in  DATA_W  store data (second register operand).
- write_reg  in  REG_W  destination register index.
- wb_ctrl  in  2  {regwrite, memtoreg}.
- m_ctrl  in  3  {branch, memread, memwrite}.
- valid_out  out  1  memory-stage instruction valid.
- target_out  out  DATA_W  registered branch target.
- zero_out  out  1  registered zero flag.
- alu_result_out  out  DATA_W  registered ALU result / memory address.
- rt_data_out  out  DATA_W  registered store data.
- write_reg_out  out  REG_W  registered destination index.
- wb_ctrl_out  out  2  registered WB control.
- memread_out  out  1  registered memread.
- memwrite_out  out  1  registered memwrite.
- pcsrc  out  1  take branch (to PC mux).
- retired_cnt  out  CNT_W  count of valid instructions captured.
- taken_cnt  out  CNT_W  count of taken branches captured.

Behaviour:
- Reset (rst_n low, asynchronous): every output goes to 0, including both counters. Reset takes effect immediately and overrides stall, flush and any in-progress capture.
- Target arithmetic: target = npc + (imm_ext << 2), modulo 2^DATA_W. Overflow wraps silently.
- Priority on each rising edge: flush > stall > capture > bubble.
- Flush:
  - valid_out, pcsrc, memread_out, memwrite_out and wb_ctrl_out become 0.
  - Data registers (target_out, zero_out, alu_result_out, rt_data_out, write_reg_out) hold their previous values.
  - Counters do not change.
- Stall (no flush): every register, including the counters, holds its value.
- Capture (no flush, no stall, in_valid = 1):
  - All data and control inputs are registered; valid_out becomes 1.
  - pcsrc becomes m_ctrl[2] & alu_zero.
  - retired_cnt increments by 1.
  - taken_cnt increments by 1 when the new pcsrc is 1.
- Bubble (no flush, no stall, in_valid = 0): same as flush.
- Latency: exactly 1 cycle from input to output. No combinational path from inputs to outputs.
- Counter saturation: counters stop at 2^CNT_W-1 and do not wrap.
- Guarantee on outputs: memread_out, memwrite_out, wb_ctrl_out and pcsrc are never 1 while valid_out is 0.
- pcsrc is asserted for one cycle per taken branch. It stays asserted across stalls, because state holds.
- Deassertion of rst_n is synchronous to clk; the first capture happens on the first rising edge after release.

Test Plan:
1. Reset with rst_n low mid-cycle, while in_valid = 1, alu_result = 32'hFFFF_FFFF, m_ctrl = 3'b111 -> all outputs 0 immediately, with no wait for an edge.
2. Capture of an ALU subtract: alu_result = 3 (10-7), alu_zero = 0, wb_ctrl = 2'b10, m_ctrl = 3'b000, write_reg = 5'd8, in_valid = 1 -> one edge later: alu_result_out = 3, write_reg_out = 8, wb_ctrl_out = 2'b10, valid_out = 1, pcsrc = 0, retired_cnt = 1.
3. Taken branch: npc = 32'h100, imm_ext = 4, alu_zero = 1 (7-7), m_ctrl = 3'b100 -> target_out = 32'h110, pcsrc = 1, taken_cnt = 1. The same case with alu_zero = 0 -> pcsrc = 0, taken_cnt unchanged.
4. Stall then flush after capturing a load (m_ctrl = 3'b010, alu_result = 32'h40):
   - Stall for 3 cycles with changing inputs -> outputs and counters frozen.
   - Then stall = 1 and flush = 1 in the same cycle -> valid_out = 0, memread_out = 0, wb_ctrl_out = 0, alu_result_out still 32'h40.
5. Bubble and negative offset:
   - in_valid = 0 with m_ctrl = 3'b011 -> memwrite_out = 0, memread_out = 0, retired_cnt unchanged.
   - npc = 32'h10, imm_ext = 32'hFFFF_FFF8 (-8) -> target_out = 32'hFFFF_FFF0 (wraps).
6. Saturation with CNT_W = 4: 20 consecutive valid captures -> retired_cnt stops at 15. One more capture keeps it at 15.
